// File: rtl/scan_debounce_scheduler.sv
// Round-robin debounce controller: one prescaled scan tick evaluates one channel,
// flipping its debounced level after DEBOUNCE_LIMIT consecutive mismatching visits.
module scan_debounce_scheduler #(
  parameter int NUM_INPUTS     = 4,
  parameter int SCAN_DIVIDER   = 4,
  parameter int DEBOUNCE_LIMIT = 4,
  localparam int CHW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst,
  input  logic [NUM_INPUTS-1:0] i_Bouncy,
  output logic [NUM_INPUTS-1:0] o_Debounced,
  output logic                  o_Event,
  output logic [CHW-1:0]        o_Event_Chan,
  output logic                  o_Event_Level
);

  localparam int PSW  = (SCAN_DIVIDER > 1) ? $clog2(SCAN_DIVIDER) : 1;
  localparam int CNTW = (DEBOUNCE_LIMIT > 1) ? $clog2(DEBOUNCE_LIMIT) : 1;
  localparam logic [PSW-1:0]  PS_LAST  = PSW'(SCAN_DIVIDER - 1);
  localparam logic [CHW-1:0]  PTR_LAST = CHW'(NUM_INPUTS - 1);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DEBOUNCE_LIMIT - 1);

  logic [NUM_INPUTS-1:0] sync1_q, sync2_q;
  logic [PSW-1:0]        presc_q, presc_d;
  logic [CHW-1:0]        ptr_q, ptr_d;
  logic [CNTW-1:0]       cnt_q [NUM_INPUTS];
  logic [CNTW-1:0]       cnt_d [NUM_INPUTS];
  logic [NUM_INPUTS-1:0] deb_q, deb_d;
  logic                  event_q, event_d;
  logic [CHW-1:0]        chan_q, chan_d;
  logic                  level_q, level_d;
  logic                  tick_s;

  assign tick_s = (presc_q == PS_LAST);

  // Next-state: prescaler, pointer and the single shared per-tick channel evaluation
  always_comb begin
    presc_d = tick_s ? {PSW{1'b0}} : presc_q + PSW'(1);
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    deb_d   = deb_q;
    event_d = 1'b0;
    chan_d  = chan_q;
    level_d = level_q;
    if (tick_s) begin
      ptr_d = (ptr_q == PTR_LAST) ? {CHW{1'b0}} : ptr_q + CHW'(1);
      if (sync2_q[ptr_q] == deb_q[ptr_q]) begin
        cnt_d[ptr_q] = {CNTW{1'b0}};
      end else if (cnt_q[ptr_q] != CNT_LAST) begin
        cnt_d[ptr_q] = cnt_q[ptr_q] + CNTW'(1);
      end else begin
        cnt_d[ptr_q] = {CNTW{1'b0}};
        deb_d[ptr_q] = sync2_q[ptr_q];
        event_d      = 1'b1;
        chan_d       = ptr_q;
        level_d      = sync2_q[ptr_q];
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

  // State registers, including the two-flop input synchronizer
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      sync1_q <= {NUM_INPUTS{1'b0}};
      sync2_q <= {NUM_INPUTS{1'b0}};
      presc_q <= {PSW{1'b0}};
      ptr_q   <= {CHW{1'b0}};
      for (int i = 0; i < NUM_INPUTS; i++) cnt_q[i] <= {CNTW{1'b0}};
      deb_q   <= {NUM_INPUTS{1'b0}};
      event_q <= 1'b0;
      chan_q  <= {CHW{1'b0}};
      level_q <= 1'b0;
    end else begin
      sync1_q <= i_Bouncy;
      sync2_q <= sync1_q;
      presc_q <= presc_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      deb_q   <= deb_d;
      event_q <= event_d;
      chan_q  <= chan_d;
      level_q <= level_d;
    end
  end

  assign o_Debounced   = deb_q;
  assign o_Event       = event_q;
  assign o_Event_Chan  = chan_q;
  assign o_Event_Level = level_q;

endmodule

// File: tb/tb_scan_debounce_scheduler.sv
// Drives a default-divider instance and a divider-1 instance with the same stimulus
// and checks both every cycle against a visit-schedule reference model.
module tb_scan_debounce_scheduler;

  localparam int N   = 4;
  localparam int LIM = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] pins;

  logic [3:0] deb_o [2];
  logic       ev_o  [2];
  logic [1:0] ch_o  [2];
  logic       lv_o  [2];

  always #5 clk = ~clk;

  scan_debounce_scheduler #(.NUM_INPUTS(4), .SCAN_DIVIDER(4), .DEBOUNCE_LIMIT(4)) u_a (
    .i_Clk(clk), .i_Rst(rst), .i_Bouncy(pins), .o_Debounced(deb_o[0]),
    .o_Event(ev_o[0]), .o_Event_Chan(ch_o[0]), .o_Event_Level(lv_o[0]));

  scan_debounce_scheduler #(.NUM_INPUTS(4), .SCAN_DIVIDER(1), .DEBOUNCE_LIMIT(4)) u_b (
    .i_Clk(clk), .i_Rst(rst), .i_Bouncy(pins), .o_Debounced(deb_o[1]),
    .o_Event(ev_o[1]), .o_Event_Chan(ch_o[1]), .o_Event_Level(lv_o[1]));

  int tests = 0;
  int fails = 0;
  int ev_cnt [2];

  // Reference model: edges since reset decide tick and visited channel arithmetically
  int         sd    [2] = '{4, 1};
  int         m_k   [2];
  logic [3:0] m_hist1 [2];
  logic [3:0] m_hist2 [2];
  logic [3:0] m_deb [2];
  int         m_run [2][4];
  logic       m_ev  [2];
  int         m_ch  [2];
  logic       m_lv  [2];

  task automatic check(input string tag, input int i, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h at %0t", tag, i, got, exp, $time);
    end
  endtask

  task automatic model_edge(input int i);
    logic [3:0] s;
    int p;
    if (rst) begin
      m_k[i] = 0; m_hist1[i] = 4'h0; m_hist2[i] = 4'h0; m_deb[i] = 4'h0;
      for (int c = 0; c < N; c++) m_run[i][c] = 0;
      m_ev[i] = 1'b0; m_ch[i] = 0; m_lv[i] = 1'b0;
    end else begin
      s = m_hist2[i];
      m_ev[i] = 1'b0;
      if ((m_k[i] % sd[i]) == sd[i] - 1) begin
        p = (m_k[i] / sd[i]) % N;
        if (s[p] == m_deb[i][p]) m_run[i][p] = 0;
        else if (m_run[i][p] + 1 < LIM) m_run[i][p] = m_run[i][p] + 1;
        else begin
          m_run[i][p] = 0;
          m_deb[i][p] = s[p];
          m_ev[i] = 1'b1; m_ch[i] = p; m_lv[i] = s[p];
        end
      end
      m_k[i] = m_k[i] + 1;
      m_hist2[i] = m_hist1[i];
      m_hist1[i] = pins;
    end
  endtask

  task automatic step(input logic r, input logic [3:0] v);
    rst = r; pins = v;
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    for (int i = 0; i < 2; i++) begin
      check("debounced", i, {28'd0, deb_o[i]}, {28'd0, m_deb[i]});
      check("event", i, {31'd0, ev_o[i]}, {31'd0, m_ev[i]});
      check("event_chan", i, {30'd0, ch_o[i]}, m_ch[i]);
      check("event_level", i, {31'd0, lv_o[i]}, {31'd0, m_lv[i]});
      if (ev_o[i]) ev_cnt[i]++;
    end
  endtask

  task automatic hold(input logic [3:0] v, input int n);
    for (int c = 0; c < n; c++) step(1'b0, v);
  endtask

  initial begin
    rst = 1'b1; pins = 4'hF;
    ev_cnt[0] = 0; ev_cnt[1] = 0;
    // Reset with all pins high: outputs stay zero
    for (int c = 0; c < 3; c++) step(1'b1, 4'hF);
    check("reset_deb", 0, {28'd0, deb_o[0]}, 32'd0);
    hold(4'h0, 4);

    // Clean press on channel 2
    ev_cnt[0] = 0; ev_cnt[1] = 0;
    hold(4'b0100, 96);
    check("press_events", 0, ev_cnt[0], 32'd1);
    check("press_events", 1, ev_cnt[1], 32'd1);
    check("press_level", 0, {28'd0, deb_o[0]}, 32'h4);

    // Release of channel 2
    ev_cnt[0] = 0;
    hold(4'b0000, 96);
    check("release_events", 0, ev_cnt[0], 32'd1);
    check("release_level", 0, {28'd0, deb_o[0]}, 32'h0);

    // Bounce on channel 1: three high visits, one low, then steady high
    ev_cnt[0] = 0;
    hold(4'b0010, 48);
    hold(4'b0000, 16);
    check("bounce_no_event", 0, ev_cnt[0], 32'd0);
    hold(4'b0010, 96);
    check("bounce_events", 0, ev_cnt[0], 32'd1);
    check("bounce_level", 0, {28'd0, deb_o[0]}, 32'h2);
    hold(4'b0000, 96);

    // All channels rise together
    ev_cnt[0] = 0;
    hold(4'hF, 112);
    check("simul_events", 0, ev_cnt[0], 32'd4);
    check("simul_level", 0, {28'd0, deb_o[0]}, 32'hF);
    hold(4'h0, 112);

    // Reset mid-count on channel 3 discards progress
    ev_cnt[0] = 0;
    hold(4'b1000, 48);
    step(1'b1, 4'b1000);
    hold(4'b1000, 40);
    check("rst_mid_no_event", 0, ev_cnt[0], 32'd0);
    hold(4'b1000, 64);
    check("rst_mid_events", 0, ev_cnt[0], 32'd1);
    hold(4'h0, 96);

    // Randomized pin activity with occasional resets
    for (int seg = 0; seg < 150; seg++) begin
      logic [3:0] v;
      int len;
      v = 4'($urandom_range(0, 15));
      len = $urandom_range(1, 40);
      if ($urandom_range(0, 60) == 0) step(1'b1, v);
      hold(v, len);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
